// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding shared memory port.
// Optional bus timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_Req,
  input  logic [31:0] I_Addr,
  input  logic        I_Kill,
  output logic        I_Ack,
  output logic [31:0] I_RData,
  output logic        Icache_StallReq,
  input  logic        D_Req,
  input  logic        D_We,
  input  logic [1:0]  D_Width,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_WData,
  output logic        D_Ack,
  output logic [31:0] D_RData,
  output logic        Dcache_StallReq,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [1:0]  Mem_Width,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic        Arb_BusErr
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] StreakSat = SW'(STREAK_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]    width_q, width_d;
  logic          we_q, we_d;
  logic          drop_q, drop_d;
  logic          i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic          buserr_q, buserr_d;
  logic          i_elig, d_elig, i_wins, expire, done;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = '0;
    expire = 1'b0;
    if (state_q != StIdle && !Mem_Ack) begin
      if (tcnt_q == TLast) expire = 1'b1;
      else                 tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // The port acked this cycle cannot be re-granted; priority still uses raw requests,
  // so a winning-but-ineligible port makes the arbiter idle for one cycle.
  assign i_elig = I_Req & ~i_ack_q;
  assign d_elig = D_Req & ~d_ack_q;
  assign i_wins = I_Req & (~D_Req | (streak_q == StreakSat));
  assign done   = Mem_Ack | expire;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    we_d     = we_q;
    drop_d   = drop_q;
    i_ack_d  = 1'b0;
    d_ack_d  = 1'b0;
    rdata_d  = '0;
    buserr_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (i_wins) begin
          if (i_elig) begin
            state_d  = StIBusy;
            addr_d   = I_Addr;
            we_d     = 1'b0;
            width_d  = 2'd0;
            wdata_d  = '0;
            streak_d = '0;
          end
        end else if (d_elig) begin
          state_d = StDBusy;
          addr_d  = D_Addr;
          we_d    = D_We;
          width_d = D_Width;
          wdata_d = D_WData;
          if (I_Req && streak_q != StreakSat) streak_d = streak_q + SW'(1);
        end
      end
      StIBusy: begin
        if (I_Kill) drop_d = 1'b1;
        if (done) begin
          state_d  = StIdle;
          i_ack_d  = ~(drop_q | I_Kill);
          rdata_d  = Mem_Ack ? Mem_RData : '0;
          buserr_d = expire;
          drop_d   = 1'b0;
        end
      end
      StDBusy: begin
        if (done) begin
          state_d  = StIdle;
          d_ack_d  = 1'b1;
          rdata_d  = Mem_Ack ? Mem_RData : '0;
          buserr_d = expire;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!I_Req) streak_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      width_q  <= '0;
      we_q     <= 1'b0;
      drop_q   <= 1'b0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      width_q  <= width_d;
      we_q     <= we_d;
      drop_q   <= drop_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  assign Mem_Req   = (state_q != StIdle);
  assign Mem_Addr  = Mem_Req ? addr_q : '0;
  assign Mem_We    = (state_q == StDBusy) & we_q;
  assign Mem_Width = (state_q == StDBusy) ? width_q : 2'd0;
  assign Mem_WData = (state_q == StDBusy) ? wdata_q : '0;

  assign I_Ack   = i_ack_q;
  assign D_Ack   = d_ack_q;
  assign I_RData = i_ack_q ? rdata_q : '0;
  assign D_RData = d_ack_q ? rdata_q : '0;

  assign Icache_StallReq = I_Req & ~I_Ack;
  assign Dcache_StallReq = D_Req & ~D_Ack;
  assign Arb_BusErr      = buserr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; covers the timeout path when
// built with ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        I_Req, I_Kill, I_Ack, Icache_StallReq;
  logic [31:0] I_Addr, I_RData;
  logic        D_Req, D_We, D_Ack, Dcache_StallReq;
  logic [1:0]  D_Width, Mem_Width;
  logic [31:0] D_Addr, D_WData, D_RData;
  logic        Mem_Req, Mem_We, Mem_Ack, Arb_BusErr;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  mem_arbiter #(.STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Kill(I_Kill), .I_Ack(I_Ack), .I_RData(I_RData),
    .Icache_StallReq(Icache_StallReq),
    .D_Req(D_Req), .D_We(D_We), .D_Width(D_Width), .D_Addr(D_Addr), .D_WData(D_WData),
    .D_Ack(D_Ack), .D_RData(D_RData), .Dcache_StallReq(Dcache_StallReq),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Width(Mem_Width), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
    .Arb_BusErr(Arb_BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!Mem_Req && n < 20) begin
      cyc();
      n++;
    end
    chk("mem_req_seen", {31'd0, Mem_Req}, 32'd1);
  endtask

  // Called in the first Mem_Req cycle; returns in the owner's Ack cycle.
  task automatic serve(input int lat, input logic [31:0] rd);
    repeat (lat) cyc();
    Mem_Ack   = 1'b1;
    Mem_RData = rd;
    cyc();
    Mem_Ack   = 1'b0;
    Mem_RData = '0;
  endtask

  initial begin
    logic exp_d;
    rst_n = 1'b0; I_Req = 1'b0; I_Addr = '0; I_Kill = 1'b0;
    D_Req = 1'b0; D_We = 1'b0; D_Width = '0; D_Addr = '0; D_WData = '0;
    Mem_Ack = 1'b0; Mem_RData = '0;
    cyc(); cyc();
    chk("rst_mem_req", {31'd0, Mem_Req}, 32'd0);
    chk("rst_i_ack", {31'd0, I_Ack}, 32'd0);
    chk("rst_d_ack", {31'd0, D_Ack}, 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Fetch only, memory acks two cycles after Mem_Req rises
    I_Req = 1'b1; I_Addr = 32'h100;
    #1 chk("i_stall_pending", {31'd0, Icache_StallReq}, 32'd1);
    cyc();
    chk("i_mem_req", {31'd0, Mem_Req}, 32'd1);
    chk("i_mem_addr", Mem_Addr, 32'h100);
    chk("i_mem_we", {31'd0, Mem_We}, 32'd0);
    chk("i_mem_wdata", Mem_WData, 32'd0);
    cyc();
    chk("i_no_early_ack", {31'd0, I_Ack}, 32'd0);
    serve(1, 32'h1234_5678);
    chk("i_ack", {31'd0, I_Ack}, 32'd1);
    chk("i_rdata", I_RData, 32'h1234_5678);
    chk("i_stall_ack", {31'd0, Icache_StallReq}, 32'd0);
    chk("i_req_drop", {31'd0, Mem_Req}, 32'd0);
    I_Req = 1'b0;
    cyc();
    chk("i_ack_pulse", {31'd0, I_Ack}, 32'd0);
    chk("i_rdata_zero", I_RData, 32'd0);

    // Data store
    D_Req = 1'b1; D_We = 1'b1; D_Width = 2'd2; D_Addr = 32'h2000; D_WData = 32'hDEAD_BEEF;
    cyc();
    chk("st_mem_we", {31'd0, Mem_We}, 32'd1);
    chk("st_mem_wdata", Mem_WData, 32'hDEAD_BEEF);
    chk("st_mem_width", {30'd0, Mem_Width}, 32'd2);
    chk("st_mem_addr", Mem_Addr, 32'h2000);
    serve(1, 32'd0);
    chk("st_d_ack", {31'd0, D_Ack}, 32'd1);
    D_Req = 1'b0; D_We = 1'b0; D_Width = '0; D_WData = '0;
    cyc();
    chk("st_d_ack_pulse", {31'd0, D_Ack}, 32'd0);
    chk("st_idle_we", {31'd0, Mem_We}, 32'd0);

    // Both held: D,D,D,D,I repeating
    I_Req = 1'b1; I_Addr = 32'h300;
    D_Req = 1'b1; D_Addr = 32'h400;
    for (int g = 0; g < 10; g++) begin
      wait_req();
      exp_d = (g % 5) != 4;
      chk("grant_order", {31'd0, Mem_Addr == 32'h400}, {31'd0, exp_d});
      serve(0, 32'h1000 + g);
      if (exp_d) chk("streak_d_rdata", D_RData, 32'h1000 + g);
      else       chk("streak_i_rdata", I_RData, 32'h1000 + g);
    end
    I_Req = 1'b0; D_Req = 1'b0;
    cyc(); cyc();

    // Kill during I_BUSY, then a data load
    I_Req = 1'b1; I_Addr = 32'h500;
    cyc();
    I_Kill = 1'b1;
    cyc();
    I_Kill = 1'b0; I_Req = 1'b0;
    chk("kill_req_held", {31'd0, Mem_Req}, 32'd1);
    chk("kill_addr_held", Mem_Addr, 32'h500);
    serve(1, 32'hAAAA_5555);
    chk("kill_no_ack", {31'd0, I_Ack}, 32'd0);
    chk("kill_rdata_zero", I_RData, 32'd0);
    D_Req = 1'b1; D_Addr = 32'h600;
    cyc();
    chk("post_kill_d_addr", Mem_Addr, 32'h600);
    serve(0, 32'hCAFE_F00D);
    chk("post_kill_d_ack", {31'd0, D_Ack}, 32'd1);
    chk("post_kill_d_rdata", D_RData, 32'hCAFE_F00D);
    chk("d_stall_ack", {31'd0, Dcache_StallReq}, 32'd0);
    D_Req = 1'b0;
    cyc();

    // Kill coinciding with the Mem_Ack cycle
    I_Req = 1'b1; I_Addr = 32'h700;
    cyc();
    Mem_Ack = 1'b1; Mem_RData = 32'h1; I_Kill = 1'b1;
    cyc();
    Mem_Ack = 1'b0; Mem_RData = '0; I_Kill = 1'b0; I_Req = 1'b0;
    chk("kill_ack_cycle_no_ack", {31'd0, I_Ack}, 32'd0);
    chk("kill_ack_cycle_idle", {31'd0, Mem_Req}, 32'd0);
    cyc();

    // Reset mid data transaction, then stray Mem_Ack
    D_Req = 1'b1; D_Addr = 32'h800;
    cyc();
    chk("rst_mid_busy", {31'd0, Mem_Req}, 32'd1);
    rst_n = 1'b0; D_Req = 1'b0;
    cyc();
    chk("rst_mid_req", {31'd0, Mem_Req}, 32'd0);
    chk("rst_mid_addr", Mem_Addr, 32'd0);
    chk("rst_mid_dstall", {31'd0, Dcache_StallReq}, 32'd0);
    rst_n = 1'b1; Mem_Ack = 1'b1; Mem_RData = 32'hFFFF;
    cyc();
    Mem_Ack = 1'b0; Mem_RData = '0;
    chk("stray_no_dack", {31'd0, D_Ack}, 32'd0);
    chk("stray_drdata", D_RData, 32'd0);
    cyc();
    chk("stray_no_dack_late", {31'd0, D_Ack}, 32'd0);
    chk("stray_idle", {31'd0, Mem_Req}, 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Memory never acks: abort 8 cycles after Mem_Req rises
    I_Req = 1'b1; I_Addr = 32'h900;
    cyc();
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk("to_wait_req", {31'd0, Mem_Req}, 32'd1);
      chk("to_wait_err", {31'd0, Arb_BusErr}, 32'd0);
    end
    cyc();
    chk("to_req_low", {31'd0, Mem_Req}, 32'd0);
    chk("to_i_ack", {31'd0, I_Ack}, 32'd1);
    chk("to_buserr", {31'd0, Arb_BusErr}, 32'd1);
    chk("to_rdata", I_RData, 32'd0);
    I_Req = 1'b0;
    cyc();
    chk("to_buserr_pulse", {31'd0, Arb_BusErr}, 32'd0);
`else
    chk("buserr_tied", {31'd0, Arb_BusErr}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
